// File: rtl/led_matrix_pkg.sv
// Shared definitions for the LED matrix controller: register map, CTRL layout,
// register-select decode and PWM range.
package led_matrix_pkg;

    // Word offsets, i.e. byte address bits [7:2]
    localparam logic [5:0] REG_CTRL     = 6'h00;
    localparam logic [5:0] REG_STATUS   = 6'h01;
    localparam logic [5:0] REG_SCAN_DIV = 6'h02;
    localparam logic [5:0] REG_FB_BASE  = 6'h10;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_BRIGHT_LSB = 4;
    localparam int CTRL_INVERT_BIT = 8;

    localparam logic [3:0] PWM_MAX    = 4'd14;
    localparam logic [3:0] BRIGHT_RST = 4'hF;

    typedef struct packed {
        logic       invert;
        logic [3:0] bright;
        logic       en;
    } ctrl_t;

    localparam ctrl_t CTRL_RST = '{invert: 1'b0, bright: BRIGHT_RST, en: 1'b0};

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_STATUS,
        SEL_SCAN_DIV,
        SEL_FB
    } reg_sel_e;

    function automatic logic [31:0] ctrl_pack(input ctrl_t c);
        logic [31:0] w;
        w                         = '0;
        w[CTRL_EN_BIT]            = c.en;
        w[CTRL_BRIGHT_LSB +: 4]   = c.bright;
        w[CTRL_INVERT_BIT]        = c.invert;
        return w;
    endfunction

    // FB words occupy 0x40..0x7C; only the first `rows` of them are mapped.
    function automatic reg_sel_e reg_decode(input logic [5:0] word, input int rows);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (word == REG_CTRL)
            sel = SEL_CTRL;
        else if (word == REG_STATUS)
            sel = SEL_STATUS;
        else if (word == REG_SCAN_DIV)
            sel = SEL_SCAN_DIV;
        else if ((word[5:4] == REG_FB_BASE[5:4]) && ({28'd0, word[3:0]} < rows))
            sel = SEL_FB;
        return sel;
    endfunction

endpackage

// File: rtl/led_matrix_if.sv
// Register-access strobes between the Wishbone adapter (master) and the
// LED matrix controller (slave).
interface led_matrix_if;
    logic [31:0] led_addr_i;
    logic [31:0] led_wdata_i;
    logic        led_we_i;
    logic [31:0] led_rdata_o;

    modport master (
        output led_addr_i,
        output led_wdata_i,
        output led_we_i,
        input  led_rdata_o
    );

    modport slave (
        input  led_addr_i,
        input  led_wdata_i,
        input  led_we_i,
        output led_rdata_o
    );
endinterface

// File: rtl/led_matrix_scanner.sv
// Row scanner: period/row/PWM/frame counters, per-row framebuffer latch and
// registered row/column drive with blanking and optional inversion.
module led_matrix_scanner
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst,
    input  logic            en_i,
    input  logic [3:0]      bright_i,
    input  logic            invert_i,
    input  logic [15:0]     scan_div_i,
    input  logic [COLS-1:0] fb_row_i,
    output logic [3:0]      row_idx_o,
    output logic [15:0]     frame_cnt_o,
    output logic [ROWS-1:0] row_o,
    output logic [COLS-1:0] col_o,
    output logic            frame_done_o
);

    localparam logic [3:0]      ROW_LAST  = 4'(ROWS - 1);
    localparam logic [15:0]     BLANK_END = 16'(BLANK_CYCLES);
    localparam logic [ROWS-1:0] ROW_ONE   = ROWS'(1);

    logic [15:0]     cnt_q, cnt_d;
    logic [3:0]      row_q, row_d;
    logic [3:0]      pwm_q, pwm_d;
    logic [15:0]     frame_q, frame_d;
    logic [COLS-1:0] row_buf_q, row_buf_d;
    logic [ROWS-1:0] row_out_q, row_out_d;
    logic [COLS-1:0] col_out_q, col_out_d;
    logic            frame_done_q, frame_done_d;

    logic terminal;
    logic wrap;
    logic active;
    logic lit;

    // >= rather than == so that lowering SCAN_DIV mid-row ends the row at once.
    assign terminal = cnt_q >= scan_div_i;
    assign wrap     = terminal && (row_q == ROW_LAST);
    assign active   = en_i && (cnt_q >= BLANK_END);
    assign lit      = pwm_q < bright_i;

    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned (no latch).
        cnt_d        = '0;
        row_d        = '0;
        pwm_d        = '0;
        frame_d      = frame_q;
        frame_done_d = 1'b0;
        // The row word is captured at cnt==0 and used from that same cycle.
        row_buf_d    = (cnt_q == '0) ? fb_row_i : row_buf_q;
        row_out_d    = {ROWS{invert_i}};
        col_out_d    = {COLS{invert_i}};

        if (en_i) begin
            cnt_d = terminal ? '0 : cnt_q + 16'd1;
            row_d = terminal ? (wrap ? '0 : row_q + 4'd1) : row_q;
            pwm_d = (pwm_q == PWM_MAX) ? '0 : pwm_q + 4'd1;
            if (wrap) begin
                frame_d      = frame_q + 16'd1;
                frame_done_d = 1'b1;
            end
        end

        if (active) begin
            row_out_d = (ROW_ONE << row_q) ^ {ROWS{invert_i}};
            col_out_d = (lit ? row_buf_d : '0) ^ {COLS{invert_i}};
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (rst) begin
            cnt_q        <= '0;
            row_q        <= '0;
            pwm_q        <= '0;
            frame_q      <= '0;
            row_buf_q    <= '0;
            row_out_q    <= '0;
            col_out_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            row_q        <= row_d;
            pwm_q        <= pwm_d;
            frame_q      <= frame_d;
            row_buf_q    <= row_buf_d;
            row_out_q    <= row_out_d;
            col_out_q    <= col_out_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign row_idx_o    = row_q;
    assign frame_cnt_o  = frame_q;
    assign row_o        = row_out_q;
    assign col_o        = col_out_q;
    assign frame_done_o = frame_done_q;

endmodule

// File: rtl/led_matrix_ctrl.sv
// LED matrix controller top: register file, address decode, registered read
// mux and framebuffer, feeding the row scanner.
module led_matrix_ctrl
    import led_matrix_pkg::*;
#(
    parameter int ROWS         = 8,
    parameter int COLS         = 8,
    parameter int SCAN_DIV_RST = 999,
    parameter int BLANK_CYCLES = 4
) (
    input  logic            clk_i,
    input  logic            rst,
    led_matrix_if.slave     bus_if,
    output logic [ROWS-1:0] row_o,
    output logic [COLS-1:0] col_o,
    output logic            frame_done_o
);

    logic [5:0]      word_idx;
    logic [3:0]      fb_idx;
    reg_sel_e        sel;

    ctrl_t           ctrl_q, ctrl_d;
    logic [15:0]     scan_div_q, scan_div_d;
    logic [COLS-1:0] fb_q [ROWS];
    logic [COLS-1:0] fb_d [ROWS];
    logic [31:0]     rdata_q, rdata_d;

    logic [3:0]      row_idx;
    logic [15:0]     frame_cnt;
    logic [COLS-1:0] fb_row;

    logic            unused_bits;

    assign word_idx    = bus_if.led_addr_i[7:2];
    assign fb_idx      = word_idx[3:0];
    assign sel         = reg_decode(word_idx, ROWS);
    assign unused_bits = ^{bus_if.led_addr_i[31:8], bus_if.led_addr_i[1:0], bus_if.led_wdata_i};

    // Write path; STATUS and unmapped offsets fall through untouched.
    always_comb begin
        ctrl_d     = ctrl_q;
        scan_div_d = scan_div_q;
        fb_d       = fb_q;
        if (bus_if.led_we_i) begin
            case (sel)
                SEL_CTRL: begin
                    ctrl_d.en     = bus_if.led_wdata_i[CTRL_EN_BIT];
                    ctrl_d.bright = bus_if.led_wdata_i[CTRL_BRIGHT_LSB +: 4];
                    ctrl_d.invert = bus_if.led_wdata_i[CTRL_INVERT_BIT];
                end
                SEL_SCAN_DIV: scan_div_d = bus_if.led_wdata_i[15:0];
                SEL_FB: begin
                    for (int r = 0; r < ROWS; r++) begin
                        if (fb_idx == 4'(r))
                            fb_d[r] = bus_if.led_wdata_i[COLS-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

    // Read data is built from next-state values so read-after-write returns the new value.
    always_comb begin
        rdata_d = '0;
        case (sel)
            SEL_CTRL:     rdata_d = ctrl_pack(ctrl_d);
            SEL_STATUS:   rdata_d = {frame_cnt, 12'd0, row_idx};
            SEL_SCAN_DIV: rdata_d = {16'd0, scan_div_d};
            SEL_FB: begin
                for (int r = 0; r < ROWS; r++) begin
                    if (fb_idx == 4'(r))
                        rdata_d = 32'(fb_d[r]);
                end
            end
            default:      rdata_d = '0;
        endcase
    end

    always_comb begin
        fb_row = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_idx == 4'(r))
                fb_row = fb_q[r];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst) begin
            ctrl_q     <= CTRL_RST;
            scan_div_q <= 16'(SCAN_DIV_RST);
            rdata_q    <= '0;
            // NOTE: the framebuffer is flop storage that must read 0 after reset, so every word is cleared explicitly.
            for (int r = 0; r < ROWS; r++)
                fb_q[r] <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            scan_div_q <= scan_div_d;
            rdata_q    <= rdata_d;
            for (int r = 0; r < ROWS; r++)
                fb_q[r] <= fb_d[r];
        end
    end

    assign bus_if.led_rdata_o = rdata_q;

    led_matrix_scanner #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_scanner (
        .clk_i        (clk_i),
        .rst          (rst),
        .en_i         (ctrl_q.en),
        .bright_i     (ctrl_q.bright),
        .invert_i     (ctrl_q.invert),
        .scan_div_i   (scan_div_q),
        .fb_row_i     (fb_row),
        .row_idx_o    (row_idx),
        .frame_cnt_o  (frame_cnt),
        .row_o        (row_o),
        .col_o        (col_o),
        .frame_done_o (frame_done_o)
    );

endmodule

// File: tb/tb_led_matrix_ctrl.sv
// Directed bench for led_matrix_ctrl: register map, scan timing, PWM, inversion,
// row-buffer tearing, SCAN_DIV lowering and reset. Inputs change on negedge.
module tb_led_matrix_ctrl;

    localparam int ROWS = 8;
    localparam int COLS = 8;

    logic            clk_i = 1'b0;
    logic            rst;
    logic [ROWS-1:0] row_o;
    logic [COLS-1:0] col_o;
    logic            frame_done_o;

    int          checks   = 0;
    int          failures = 0;
    int          edges    = 0;
    int          base     = 0;
    int          cnt;
    logic [31:0] rd;

    led_matrix_if bus ();

    led_matrix_ctrl #(
        .ROWS         (ROWS),
        .COLS         (COLS),
        .SCAN_DIV_RST (999),
        .BLANK_CYCLES (4)
    ) dut (
        .clk_i        (clk_i),
        .rst          (rst),
        .bus_if       (bus),
        .row_o        (row_o),
        .col_o        (col_o),
        .frame_done_o (frame_done_o)
    );

    always #5 clk_i = ~clk_i;
    always @(posedge clk_i) edges <= edges + 1;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at a negedge.
    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        bus.led_addr_i  = addr;
        bus.led_wdata_i = data;
        bus.led_we_i    = 1'b1;
        @(negedge clk_i);
        bus.led_we_i    = 1'b0;
    endtask

    task automatic bus_write2(input logic [31:0] addr, input logic [31:0] data);
        bus.led_addr_i  = addr;
        bus.led_wdata_i = data;
        bus.led_we_i    = 1'b1;
        repeat (2) @(negedge clk_i);
        bus.led_we_i    = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        bus.led_addr_i = addr;
        bus.led_we_i   = 1'b0;
        @(negedge clk_i);
        data = bus.led_rdata_o;
    endtask

    // Edge 1 is the edge that committed the enabling CTRL write.
    task automatic mark();
        base = edges;
    endtask

    task automatic goto_edge(input int m);
        int guard;
        guard = 0;
        while ((edges - base + 1) < m && guard < 5000) begin
            @(negedge clk_i);
            guard++;
        end
        if (guard >= 5000) begin
            checks++;
            failures++;
            $error("FAIL goto_edge observed=%0d expected=%0d", edges - base + 1, m);
        end
    endtask

    initial begin
        bus.led_addr_i  = '0;
        bus.led_wdata_i = '0;
        bus.led_we_i    = 1'b0;
        rst             = 1'b1;
        repeat (3) @(negedge clk_i);
        rst = 1'b0;

        // Reset state
        check("rst_row", 32'(row_o), 32'h0);
        check("rst_col", 32'(col_o), 32'h0);
        check("rst_frame_done", 32'(frame_done_o), 32'h0);
        bus_read(32'h00, rd); check("rst_ctrl", rd, 32'h0000_00F0);
        bus_read(32'h04, rd); check("rst_status", rd, 32'h0);
        bus_read(32'h08, rd); check("rst_scan_div", rd, 32'd999);
        bus_read(32'h40, rd); check("rst_fb0", rd, 32'h0);
        bus_read(32'h5C, rd); check("rst_fb7", rd, 32'h0);
        bus_read(32'h3C, rd); check("rst_unmapped", rd, 32'h0);
        bus_read(32'h108, rd); check("upper_addr_ignored", rd, 32'd999);

        // Register programming
        bus_write(32'h40, 32'h0000_00A5);
        bus_write(32'h5C, 32'h0000_003C);
        bus_write(32'h44, 32'hFFFF_FFFF);
        check("fb1_raw_upper_bits", bus.led_rdata_o, 32'h0000_00FF);
        bus_write(32'h48, 32'h0000_000F);
        bus_write(32'h54, 32'h0000_005A);
        bus_write(32'h04, 32'hFFFF_FFFF);
        bus_read(32'h04, rd); check("status_write_ignored", rd, 32'h0);
        bus_write(32'h3C, 32'h0000_1234);
        bus_read(32'h3C, rd); check("unmapped_write_ignored", rd, 32'h0);
        bus_write(32'h08, 32'd9);
        check("scan_div_raw", bus.led_rdata_o, 32'd9);

        // Scanning, SCAN_DIV=9: row r active for outputs at edges 10r+6..10r+11
        bus_write(32'h00, 32'h0000_00F1);
        mark();
        goto_edge(5);  check("blank_row", 32'(row_o), 32'h00); check("blank_col", 32'(col_o), 32'h00);
        goto_edge(6);  check("r0_first_row", 32'(row_o), 32'h01); check("r0_first_col", 32'(col_o), 32'hA5);
        goto_edge(11); check("r0_last_row", 32'(row_o), 32'h01); check("r0_last_col", 32'(col_o), 32'hA5);
        goto_edge(12); check("r1_blank_row", 32'(row_o), 32'h00);
        goto_edge(16); check("r1_row", 32'(row_o), 32'h02); check("r1_col", 32'(col_o), 32'hFF);
        goto_edge(76); check("r7_row", 32'(row_o), 32'h80); check("r7_col", 32'(col_o), 32'h3C);
        goto_edge(80); check("fd_before", 32'(frame_done_o), 32'h0);
        goto_edge(81); check("fd_pulse", 32'(frame_done_o), 32'h1);
        goto_edge(82); check("fd_after", 32'(frame_done_o), 32'h0);
        bus_read(32'h04, rd); check("status_frame1", rd, 32'h0001_0000);
        cnt = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk_i);
            if (frame_done_o) cnt++;
        end
        check("fd_count_160", 32'(cnt), 32'd2);
        bus_read(32'h04, rd); check("status_frame3", rd, 32'h0003_0000);

        // Disable mid-scan, then PWM with BRIGHT=4, SCAN_DIV=99
        bus_write(32'h00, 32'h0000_0000);
        @(negedge clk_i);
        check("dis_row", 32'(row_o), 32'h00);
        check("dis_col", 32'(col_o), 32'h00);
        bus_read(32'h04, rd); check("dis_status_row", rd & 32'hF, 32'h0);
        bus_write(32'h08, 32'd99);
        bus_write(32'h00, 32'h0000_0041);
        mark();
        goto_edge(17); check("pwm_lit_row", 32'(row_o), 32'h01); check("pwm_lit_col", 32'(col_o), 32'hA5);
        goto_edge(21); check("pwm_dark_col", 32'(col_o), 32'h00);
        goto_edge(25);
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            if (col_o != '0) cnt++;
            @(negedge clk_i);
        end
        check("pwm_b4_count", 32'(cnt), 32'd4);
        bus_write(32'h00, 32'h0000_0001);
        @(negedge clk_i);
        cnt = 0;
        for (int i = 0; i < 30; i++) begin
            if (col_o != '0) cnt++;
            @(negedge clk_i);
        end
        check("pwm_b0_count", 32'(cnt), 32'd0);

        // Inverted outputs
        bus_write(32'h00, 32'h0000_0000);
        bus_write(32'h08, 32'd9);
        bus_write(32'h00, 32'h0000_01F1);
        mark();
        @(negedge clk_i);
        check("inv_blank_row", 32'(row_o), 32'hFF);
        check("inv_blank_col", 32'(col_o), 32'hFF);
        check("inv_fd", 32'(frame_done_o), 32'h0);
        goto_edge(6);
        check("inv_row0", 32'(row_o), 32'hFE);
        check("inv_col0", 32'(col_o), 32'h5A);
        bus_write(32'h00, 32'h0000_0100);
        @(negedge clk_i);
        check("inv_dis_row", 32'(row_o), 32'hFF);
        check("inv_dis_col", 32'(col_o), 32'hFF);

        // Row-buffer tearing and SCAN_DIV lowering, SCAN_DIV=99
        bus_write(32'h00, 32'h0000_0000);
        bus_write(32'h08, 32'd99);
        bus_write(32'h00, 32'h0000_00F1);
        mark();
        goto_edge(220); check("r2_old_row", 32'(row_o), 32'h04); check("r2_old_col", 32'(col_o), 32'h0F);
        bus_write(32'h48, 32'h0000_00F0);
        check("fb2_raw", bus.led_rdata_o, 32'h0000_00F0);
        goto_edge(230); check("r2_no_tear_col", 32'(col_o), 32'h0F);
        goto_edge(350);
        bus_write(32'h08, 32'd1);
        bus_read(32'h04, rd); check("lower_div_row3", rd & 32'hF, 32'h3);
        bus_read(32'h04, rd); check("lower_div_row4", rd & 32'hF, 32'h4);

        bus_write(32'h00, 32'h0000_0000);
        bus_write(32'h08, 32'd9);
        bus_write(32'h00, 32'h0000_00F1);
        mark();
        goto_edge(26); check("r2_new_row", 32'(row_o), 32'h04); check("r2_new_col", 32'(col_o), 32'hF0);
        goto_edge(58); check("r5_row", 32'(row_o), 32'h20); check("r5_col", 32'(col_o), 32'h5A);

        // Reset mid-scan
        rst = 1'b1;
        @(negedge clk_i);
        check("mid_rst_row", 32'(row_o), 32'h00);
        check("mid_rst_col", 32'(col_o), 32'h00);
        check("mid_rst_fd", 32'(frame_done_o), 32'h0);
        rst = 1'b0;
        bus_read(32'h04, rd); check("mid_rst_status", rd, 32'h0);
        bus_read(32'h54, rd); check("mid_rst_fb5", rd, 32'h0);
        bus_read(32'h00, rd); check("mid_rst_ctrl", rd, 32'h0000_00F0);
        bus_read(32'h08, rd); check("mid_rst_scan_div", rd, 32'd999);

        // Held write behaves like a single write
        bus_write2(32'h4C, 32'h0000_0077);
        check("fb3_double_raw", bus.led_rdata_o, 32'h0000_0077);
        bus_write(32'h50, 32'h0000_0077);
        bus_read(32'h4C, rd); check("fb3_double", rd, 32'h0000_0077);
        bus_read(32'h50, rd); check("fb4_single", rd, 32'h0000_0077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/led_matrix_ctrl.md
Name: led_matrix_ctrl

Overview:
- Memory-mapped LED matrix controller that sits directly downstream of the Wishbone LED-matrix slave adapter.
- Consumes the adapter's addr/wdata/we strobes and returns read data to it.
- Holds a control/status register set and a row framebuffer.
- Drives a time-multiplexed row/column LED matrix with row scanning, anti-ghost blanking and 4-bit PWM brightness.

Parameters:
- ROWS, 8, number of matrix rows (2..16)
- COLS, 8, columns per row (1..32)
- SCAN_DIV_RST, 999, reset value of SCAN_DIV; a row period is SCAN_DIV+1 cycles
- BLANK_CYCLES, 4, cycles at the start of each row period during which all outputs are inactive

Ports:
- clk_i  in  1  clock
- rst  in  1  reset, synchronous, active-high
- led_addr_i  in  32  byte address from adapter; only bits [7:2] are decoded
- led_wdata_i  in  32  write data
- led_we_i  in  1  write enable; a write is performed on every clock edge where it is high
- led_rdata_o  out  32  registered read data for led_addr_i
- row_o  out  ROWS  row drive, one-hot when active
- col_o  out  COLS  column drive for the current row
- frame_done_o  out  1  one-cycle pulse when the row index wraps from ROWS-1 to 0

Behaviour:
Register map (word offsets, upper address bits ignored):
- 0x00 CTRL, RW.
  - bit0 EN.
  - bits[7:4] BRIGHT.
  - bit8 INVERT (active-low outputs).
  - Reset: EN=0, BRIGHT=0xF, INVERT=0.
- 0x04 STATUS, RO.
  - bits[3:0] current row index.
  - bits[31:16] frame counter, 16-bit, wraps.
  - Reset: 0.
- 0x08 SCAN_DIV, RW.
  - bits[15:0] only.
  - Reset: SCAN_DIV_RST.
- 0x40+4*r FB[r] for r < ROWS, RW.
  - Bits [COLS-1:0] hold pixels; unused upper bits read 0.
  - Reset: 0.
- Unmapped offsets read 0 and ignore writes. Writes to STATUS are ignored.

Bus timing:
- A write updates the register at the clock edge where led_we_i=1.
- Repeated writes with the same data are idempotent, because the adapter holds we for two cycles.
- led_rdata_o is registered: it reflects led_addr_i from the previous cycle, plus any write completed at that edge (read-after-write returns the new value).

Scanning when EN=0:
- Row counter, period counter and PWM counter are held at 0.
- row_o, col_o and frame_done_o are inactive.
- Inactive means 0, or all-ones when INVERT=1; frame_done_o is never inverted.

Scanning when EN=1:
- The period counter cnt increments each cycle.
- When cnt >= SCAN_DIV (terminal):
  - cnt returns to 0.
  - The row index advances, wrapping from ROWS-1 to 0.
  - On wrap, the frame counter increments and frame_done_o pulses for 1 cycle.
- The >= compare means that lowering SCAN_DIV mid-row ends the row on the next cycle.
- At cnt==0 the row's FB word is latched into a row buffer. FB writes during a row take effect at the next row start (no mid-row tearing).
- Blanking: while cnt < BLANK_CYCLES, outputs are inactive. If SCAN_DIV < BLANK_CYCLES, the matrix stays permanently blank; this is legal.
- PWM: a 4-bit counter runs 0..14 and wraps every 15 cycles while EN=1.
  - Pixels are lit when pwm < BRIGHT.
  - BRIGHT=0 gives always off; BRIGHT=15 gives always on.
- Active output:
  - row_o = one-hot(row index).
  - col_o = row buffer AND lit.
  - Both are XOR'd with INVERT.
  - All outputs are registered, one cycle after internal state.

Enable and reset edge cases:
- Clearing EN mid-row forces outputs inactive on the next cycle and resets the counters.
- Setting EN starts at row 0, cnt 0.
- rst mid-scan: all registers return to reset values and outputs go inactive on the next cycle.

Decomposition:
- Package led_matrix_pkg holds:
  - register offset constants (CTRL, STATUS, SCAN_DIV, FB_BASE)
  - CTRL field bit positions
  - PWM_MAX=14
- Sub-module led_matrix_scanner contains the cnt, row index, PWM and frame counters, the row buffer latch, and the output generation. Its inputs are EN, BRIGHT, INVERT, SCAN_DIV and the FB row word, selected by the top from the row index.
- The top module holds the register file, decode and read mux.

Test Plan:
1. Reset, then read all offsets → CTRL=0x000000F0, STATUS=0, SCAN_DIV=999, FB=0, offset 0x3C=0; row_o=0, col_o=0.
2. Write FB[0]=0xA5, FB[7]=0x3C; SCAN_DIV=9; CTRL=0xF1 → row_o=0x01 with col_o=0xA5 from cnt 4..9. Row 7 shows 0x3C. frame_done_o pulses once every 80 cycles and STATUS[31:16] increments.
3. BRIGHT=4 (CTRL=0x41), SCAN_DIV=99 → within the unblanked window, col_o is non-zero for exactly 4 of every 15 cycles. BRIGHT=0 → col_o is always 0.
4. CTRL=0x1F1 (INVERT) → row_o is the one-hot inverted (e.g. 0xFE for row 0). During blank, row_o=col_o=0xFF.
5. Write FB[2] at mid-row 2 → col_o keeps the old value until row 2 is next scanned. Write SCAN_DIV=1 while cnt=50 → the row advances the next cycle.
6. Assert rst while scanning row 5 → the next cycle has outputs inactive, STATUS=0 and FB cleared. A double-cycle write of the same data leaves the register unchanged relative to a single write.
